dvi_rx_decode: RTL and testbench
================================

DVI_RX_DECODE -- requirements
Module: dvi_rx_decode

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 32: consecutive control tokens required to declare lock.
REQ-002 SHALL have parameter SEARCH_LEN, default 2048: cycles without a qualifying control run before slip (HUNT) or unlock (LOCKED).
REQ-003 SHALL have parameter SLIP_WAIT, default 4: idle cycles after each bitslip pulse.
REQ-004 SHALL have port clk  input  1  single clock, one 10-bit TMDS character per cycle.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_d  input  10  deserialized TMDS character, bit 0 first on the wire.
REQ-007 SHALL have port out_de  output  1  1 = data character, 0 = control token.
REQ-008 SHALL have port out_d  output  8  decoded pixel byte, valid when out_de=1.
REQ-009 SHALL have port out_c0  output  1  decoded control bit 0, valid when out_de=0.
REQ-010 SHALL have port out_c1  output  1  decoded control bit 1, valid when out_de=0.
REQ-011 SHALL have port out_bitslip  output  1  one-cycle pulse requesting the deserializer to shift word alignment by one bit.
REQ-012 SHALL have port out_locked  output  1  character alignment achieved.

Function
REQ-013 Decode SHALL be registered: out_de/out_d/out_c0/out_c1 reflect in_d from the previous cycle (latency 1).
REQ-014 Control tokens SHALL map to {c1,c0}: 10'b1101010100->00, 10'b0010101011->01, 10'b0101010100->10, 10'b1010101011->11; on a token out_de=0 and out_d=0.
REQ-015 Any other character SHALL set out_de=1, out_c0/out_c1 held at their last values; d = in_d[9] ? ~in_d[7:0] : in_d[7:0].
REQ-016 Data bits SHALL be out_d[0]=d[0]; for i=1..7, out_d[i]=d[i]^d[i-1] if in_d[8]=1, else ~(d[i]^d[i-1]).
REQ-017 Decode SHALL be independent of lock state.
REQ-018 Alignment FSM SHALL have states HUNT, SLIP, WAIT, LOCKED.
REQ-019 run counter SHALL increment on any control token, clear on any non-token, and saturate at LOCK_COUNT; a change between token types does not clear it.
REQ-020 search timer SHALL increment every cycle in HUNT and LOCKED and clear on entry to either state and whenever run reaches LOCK_COUNT.
REQ-021 HUNT->LOCKED when run reaches LOCK_COUNT; HUNT->SLIP when the timer reaches SEARCH_LEN-1.
REQ-022 SLIP SHALL last one cycle with out_bitslip=1, then ->WAIT; WAIT lasts SLIP_WAIT cycles with run held at 0, then ->HUNT.
REQ-023 LOCKED->HUNT (no slip) when the timer reaches SEARCH_LEN-1.
REQ-024 If the run reaching LOCK_COUNT and timer expiry coincide, lock/refresh SHALL win.
REQ-025 out_locked SHALL be 1 exactly while in LOCKED (registered); out_bitslip=1 only in SLIP.
REQ-026 Counter widths SHALL be $clog2 of their limits; no wrap-around permitted.

Reset
REQ-027 On reset_n=0 all outputs SHALL be 0, FSM in HUNT, all counters 0; asserting reset mid-slip or mid-lock aborts immediately.
REQ-028 Deassertion SHALL be sampled synchronously to clk; the first active cycle starts HUNT with the timer at 0.

Structure
REQ-029 The four control-token constants and the FSM state encodings SHALL live in a shared package/include dvi_tmds_pkg, also used by the transmit encoder.
REQ-030 The alignment FSM and counters SHALL be sub-module dvi_rx_align; the decode datapath stays in dvi_rx_decode.

Verification
REQ-031 Reset, then 32 x 10'b1101010100 -> out_locked=1 on the cycle after the 32nd token; out_de=0; {c1,c0}=00 throughout.
REQ-032 Feed 0x100, then 0x2FF -> out_d=0x00, de=1; then out_d=0xFE, de=1; one-cycle latency each.
REQ-033 Continuous 0x100 from reset -> out_bitslip pulses at cycle 2048, then every 2048+1+4 cycles; out_locked stays 0.
REQ-034 Locked, then 31 tokens and 1 data character repeated -> loses lock 2048 cycles after the last 32-token run; no bitslip is issued.
REQ-035 Alternate 0x354 and 0x0AB (tokens 00/01) x32 -> lock is achieved and c0 toggles each cycle.
REQ-036 reset_n pulsed low during SLIP and during LOCKED -> all outputs 0 in the same cycle; the FSM restarts in HUNT.

Source files
------------

// File: rtl/dvi_tmds_pkg.sv
// TMDS constants shared by the DVI receive decoder and transmit encoder:
// control-token codes, alignment FSM state encoding, token helpers.
package dvi_tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOK_00;
      2'b01:   tok = CTRL_TOK_01;
      2'b10:   tok = CTRL_TOK_10;
      default: tok = CTRL_TOK_11;
    endcase
    return tok;
  endfunction

  function automatic logic is_ctrl_token(input logic [9:0] ch);
    return (ch == CTRL_TOK_00) || (ch == CTRL_TOK_01) ||
           (ch == CTRL_TOK_10) || (ch == CTRL_TOK_11);
  endfunction

endpackage

// File: rtl/dvi_rx_align.sv
// Character alignment FSM: counts consecutive control tokens to declare lock,
// requests a one-bit word slip when no qualifying run appears within the search window.
module dvi_rx_align #(
  parameter int LOCK_COUNT = 32,
  parameter int SEARCH_LEN = 2048,
  parameter int SLIP_WAIT  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tok,
  output logic bitslip,
  output logic locked
);
  import dvi_tmds_pkg::*;

  // Run counter must hold LOCK_COUNT itself while saturated.
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int TMR_W  = (SEARCH_LEN > 2) ? $clog2(SEARCH_LEN) : 1;
  localparam int WAIT_W = (SLIP_WAIT > 2) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_COUNT);
  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(SEARCH_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SLIP_WAIT - 1);

  align_state_t      state;
  logic [RUN_W-1:0]  run;
  logic [RUN_W-1:0]  run_nxt;
  logic [TMR_W-1:0]  tmr;
  logic [WAIT_W-1:0] wcnt;
  logic              hit;

  // Token type changes keep the run going; SLIP/WAIT hold it at zero.
  always_comb begin
    run_nxt = '0;
    if ((state == ST_HUNT || state == ST_LOCKED) && tok)
      run_nxt = (run == RUN_MAX) ? run : run + 1'b1;
  end

  assign hit = (run_nxt == RUN_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_HUNT;
      run     <= '0;
      tmr     <= '0;
      wcnt    <= '0;
      bitslip <= 1'b0;
      locked  <= 1'b0;
    end else begin
      run     <= run_nxt;
      bitslip <= 1'b0;
      case (state)
        ST_HUNT: begin
          // A completed run beats a simultaneous timer expiry.
          if (hit) begin
            state  <= ST_LOCKED;
            tmr    <= '0;
            locked <= 1'b1;
          end else if (tmr == TMR_MAX) begin
            state   <= ST_SLIP;
            tmr     <= '0;
            bitslip <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_SLIP: begin
          state <= ST_WAIT;
          wcnt  <= '0;
        end
        ST_WAIT: begin
          if (wcnt == WAIT_MAX) begin
            state <= ST_HUNT;
            tmr   <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            tmr <= '0;
          end else if (tmr == TMR_MAX) begin
            state  <= ST_HUNT;
            tmr    <= '0;
            locked <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          state  <= ST_HUNT;
          tmr    <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dvi_rx_decode.sv
// DVI TMDS receive channel: registered 10b->8b / control-token decode (latency 1)
// plus word-alignment control via dvi_rx_align.
module dvi_rx_decode #(
  parameter int LOCK_COUNT = 32,
  parameter int SEARCH_LEN = 2048,
  parameter int SLIP_WAIT  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] in_d,
  output logic       out_de,
  output logic [7:0] out_d,
  output logic       out_c0,
  output logic       out_c1,
  output logic       out_bitslip,
  output logic       out_locked
);
  import dvi_tmds_pkg::*;

  logic       tok;
  logic [1:0] ctl;
  logic [7:0] d_inv;
  logic [7:0] d_dec;

  assign tok = is_ctrl_token(in_d);

  always_comb begin
    ctl = 2'b00;
    case (in_d)
      CTRL_TOK_01: ctl = 2'b01;
      CTRL_TOK_10: ctl = 2'b10;
      CTRL_TOK_11: ctl = 2'b11;
      default:     ctl = 2'b00;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain selected by bit 8.
  always_comb begin
    d_inv    = in_d[9] ? ~in_d[7:0] : in_d[7:0];
    d_dec    = '0;
    d_dec[0] = d_inv[0];
    for (int i = 1; i < 8; i++)
      d_dec[i] = in_d[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_de <= 1'b0;
      out_d  <= '0;
      out_c0 <= 1'b0;
      out_c1 <= 1'b0;
    end else if (tok) begin
      out_de <= 1'b0;
      out_d  <= '0;
      out_c0 <= ctl[0];
      out_c1 <= ctl[1];
    end else begin
      out_de <= 1'b1;
      out_d  <= d_dec;
    end
  end

  dvi_rx_align #(
    .LOCK_COUNT(LOCK_COUNT),
    .SEARCH_LEN(SEARCH_LEN),
    .SLIP_WAIT (SLIP_WAIT)
  ) u_align (
    .clk    (clk),
    .reset_n(reset_n),
    .tok    (tok),
    .bitslip(out_bitslip),
    .locked (out_locked)
  );

endmodule

// File: tb/tb_dvi_rx_decode.sv
// Directed bench for dvi_rx_decode: decode vectors, lock, slip cadence, lock loss, async reset.
module tb_dvi_rx_decode;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] in_d;
  logic       out_de;
  logic [7:0] out_d;
  logic       out_c0;
  logic       out_c1;
  logic       out_bitslip;
  logic       out_locked;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dvi_rx_decode dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_d       (in_d),
    .out_de     (out_de),
    .out_d      (out_d),
    .out_c0     (out_c0),
    .out_c1     (out_c1),
    .out_bitslip(out_bitslip),
    .out_locked (out_locked)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [9:0] v);
    in_d = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_d    = 10'h100;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [9:0] v;
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int   bad_de;
    int   bad_c;
    int   lost_at;
    int   slip_seen;
    int   lock_seen;
    int   found;
    int   pulses[$];
    logic [7:0] prev_d;

    vecs[0] = '{10'h100, 1'b1, 8'h00, 2'b01};
    vecs[1] = '{10'h2FF, 1'b1, 8'hFE, 2'b01};
    vecs[2] = '{10'h1FF, 1'b1, 8'h01, 2'b01};
    vecs[3] = '{10'h155, 1'b1, 8'hFF, 2'b01};
    vecs[4] = '{10'h000, 1'b1, 8'hFE, 2'b01};
    vecs[5] = '{10'h2AB, 1'b0, 8'h00, 2'b11};
    vecs[6] = '{10'h0AA, 1'b1, 8'h00, 2'b11};
    vecs[7] = '{10'h154, 1'b0, 8'h00, 2'b10};
    vecs[8] = '{10'h2F0, 1'b1, 8'hEF, 2'b10};
    vecs[9] = '{10'h0CC, 1'b1, 8'hAA, 2'b10};

    // Reset state
    reset_n = 1'b0;
    in_d    = 10'h2FF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_de", out_de, 0);
    check("rst_d", out_d, 0);
    check("rst_c0", out_c0, 0);
    check("rst_c1", out_c1, 0);
    check("rst_bitslip", out_bitslip, 0);
    check("rst_locked", out_locked, 0);
    reset_n = 1'b1;

    // 32 x token 00 -> lock on the cycle after the 32nd
    bad_de = 0;
    bad_c  = 0;
    for (int i = 1; i <= 32; i++) begin
      apply(10'h354);
      if (out_de !== 1'b0) bad_de++;
      if ({out_c1, out_c0} !== 2'b00) bad_c++;
      if (i == 31) check("lock31_locked", out_locked, 0);
    end
    check("lock32_locked", out_locked, 1);
    check("lock_de_tok", bad_de, 0);
    check("lock_c00", bad_c, 0);

    // Alternating tokens 00/01 still count as one run
    do_reset();
    for (int i = 0; i < 32; i++) begin
      apply((i % 2 == 0) ? 10'h354 : 10'h0AB);
      check($sformatf("alt_c0_%0d", i), out_c0, i % 2);
      if (i == 30) check("alt_locked31", out_locked, 0);
    end
    check("alt_locked32", out_locked, 1);

    // Decode vectors with one-cycle latency
    prev_d = 8'h00;
    for (int i = 0; i < 10; i++) begin
      in_d = vecs[i].v;
      #2;
      check($sformatf("lat_%0d", i), out_d, prev_d);
      @(posedge clk);
      #1;
      check($sformatf("dec_d_%0d", i), out_d, vecs[i].d);
      check($sformatf("dec_de_%0d", i), out_de, vecs[i].de);
      check($sformatf("dec_c_%0d", i), {out_c1, out_c0}, vecs[i].c);
      prev_d = vecs[i].d;
    end

    // Lock loss: 31 tokens + 1 data never refresh, unlock 2048 cycles after lock run
    do_reset();
    for (int i = 0; i < 32; i++) apply(10'h354);
    check("ll_locked", out_locked, 1);
    lost_at   = -1;
    slip_seen = 0;
    for (int k = 1; k <= 2200; k++) begin
      apply(((k - 1) % 32 == 0) ? 10'h100 : 10'h354);
      if (!out_locked && lost_at < 0) lost_at = k;
      if (out_bitslip) slip_seen++;
    end
    check("ll_lost_at", lost_at, 2048);
    check("ll_no_slip", slip_seen, 0);
    check("ll_end_locked", out_locked, 0);

    // Continuous data: slip cadence 2048 then every 2053
    do_reset();
    lock_seen = 0;
    for (int i = 1; i <= 6160; i++) begin
      apply(10'h100);
      if (out_bitslip) pulses.push_back(i);
      if (out_locked) lock_seen++;
    end
    check("slip_count", pulses.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("slip_at_%0d", k), (k < pulses.size()) ? pulses[k] : -1, 2048 + k * 2053);
    check("slip_no_lock", lock_seen, 0);
    check("slip_de", out_de, 1);

    // Reset during SLIP
    do_reset();
    found = 0;
    for (int i = 0; i < 2100 && found == 0; i++) begin
      apply(10'h100);
      if (out_bitslip) found = 1;
    end
    check("rs_slip_found", found, 1);
    reset_n = 1'b0;
    #1;
    check("rs_slip_bitslip", out_bitslip, 0);
    check("rs_slip_de", out_de, 0);
    check("rs_slip_locked", out_locked, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      apply(10'h2AB);
      if (i == 31) check("rs_relock31", out_locked, 0);
    end
    check("rs_relock32", out_locked, 1);

    // Reset during LOCKED
    apply(10'h2AB);
    apply(10'h155);
    check("rl_pre_locked", out_locked, 1);
    check("rl_pre_d", out_d, 8'hFF);
    check("rl_pre_c", {out_c1, out_c0}, 2'b11);
    reset_n = 1'b0;
    #1;
    check("rl_locked", out_locked, 0);
    check("rl_de", out_de, 0);
    check("rl_d", out_d, 0);
    check("rl_c", {out_c1, out_c0}, 0);
    check("rl_bitslip", out_bitslip, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(10'h100);
    check("rl_hunt_locked", out_locked, 0);
    check("rl_hunt_bitslip", out_bitslip, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
